grf_wb_scheduler: RTL
=====================

Name: grf_wb_scheduler

Overview:
- Write-port scheduler and hazard scoreboard for the 32x32 general register file (GRF) in the pipelined MIPS core.
- Tracks which registers have an outstanding write and stalls issue on RAW/WAW hazards.
- Arbitrates two writeback sources onto the GRF's single write port: the main pipeline WB stage and the multi-cycle mult/div (MD) unit.
- The GRF write port is driven from registered outputs; the GRF commits on the following clock edge.

Parameters:
DATA_W, 32, writeback data and pc width
NREG, 32, number of architectural registers; register index width is log2(NREG)
STARVE_LIMIT, 2, cycles an MD result may wait in the skid before pipe-issue drain stall engages

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
issue_valid  in  1  decode has an instruction to issue
issue_rs  in  5  source register 1
issue_rt  in  5  source register 2
issue_rd  in  5  destination register; 0 = no write
issue_src  in  1  writer of rd: 0 = pipeline, 1 = MD unit
issue_ready  out  1  combinational; issue accepted when issue_valid && issue_ready
pipe_wb_valid  in  1  pipeline writeback present (cannot be back-pressured)
pipe_wb_addr  in  5  pipeline writeback register
pipe_wb_data  in  32  pipeline writeback data
pipe_wb_pc  in  32  pc of the pipeline writer
md_wb_valid  in  1  MD result present
md_wb_ready  out  1  MD result accepted when valid && ready
md_wb_addr  in  5  MD result register
md_wb_data  in  32  MD result data
md_wb_pc  in  32  pc of the MD writer
grf_we  out  1  GRF write enable (registered)
grf_a3  out  5  GRF write address (registered)
grf_wd  out  32  GRF write data (registered)
grf_pc  out  32  pc for the write trace (registered)
wb_err  out  1  sticky: a writeback targeted a register that was not busy

Behaviour:
- Reset (synchronous, on the clk edge): busy[] = 0, skid empty, wait counter = 0, grf_we = 0, grf_a3 = 0, grf_wd = 0, grf_pc = 0, wb_err = 0.
  - Reset mid-operation discards any skid contents and in-flight grants.
  - The first cycle after reset has issue_ready = 1 and md_wb_ready = 1.
- Scoreboard:
  - One busy bit per register; busy[0] is hardwired 0.
  - Issue accept with issue_rd != 0 sets busy[issue_rd] at that edge.
  - busy[r] clears at the edge where grf_we = 1 and grf_a3 = r. This is the same edge on which the GRF commits, so a dependent instruction issued on the next cycle reads the new value.
- issue_ready = 0 when any of the following holds:
  - busy[issue_rs] (RAW), or busy[issue_rt] (RAW), or issue_rd != 0 && busy[issue_rd] (WAW).
  - Drain stall: issue_src = 0, issue_rd != 0, and the skid has been full for >= STARVE_LIMIT consecutive cycles.
  - A register being committed this cycle is still busy, so dependents stall one extra cycle. This is intentional.
- Arbitration, evaluated each cycle. The winner is registered onto the grf_* outputs, giving 1-cycle latency from accept to grf_we.
  - Priority: pipe_wb > skid > direct MD.
  - md_wb_ready = !skid_valid.
  - MD accepted while pipe_wb_valid: the MD result goes into the skid.
  - MD accepted with no pipe writeback and skid empty: the MD result is granted directly.
  - Skid valid with no pipe writeback: the skid drains and empties at that edge. md_wb_ready is still 0 in that cycle, so a new MD result is not accepted until the next cycle.
  - Wait counter increments each cycle the skid is full and not draining; it resets to 0 when the skid drains.
- Writeback address 0: never granted and grf_we is not asserted. The data is dropped. The pipe-vs-MD slot is still consumed.
- Writeback to a nonzero register whose busy bit is 0: the write is still performed and wb_err is set. wb_err stays set until reset.
- Idle cycle (no winner): grf_we = 0; grf_a3/grf_wd/grf_pc hold their previous values.

Decomposition:
- Shared package: register index width, REG_ZERO constant, and the source encoding constants SRC_PIPE = 0 and SRC_MD = 1.
- One sub-module, grf_wb_skid: the 1-entry holding buffer with addr/data/pc, valid flag and starve counter. The scoreboard and arbiter stay in the top module.

Test Plan:
1. RAW stall:
   - Issue rd=8, src=0 at cycle 0; pipe_wb addr=8, data=0x1234 at cycle 3.
   - grf_we=1, a3=8, wd=0x1234 at cycle 4.
   - An issue with rs=8 sees issue_ready=0 in cycles 1-4 and issue_ready=1 at cycle 5.
2. Collision:
   - Same cycle: pipe_wb addr=3, data=0xA; md_wb addr=5, data=0xB (both busy).
   - Cycle+1: grf_we with a3=3, wd=0xA. Cycle+2: a3=5, wd=0xB.
   - md_wb_ready=0 during cycle+1.
3. Drain stall:
   - Skid holds MD addr=9 while pipe_wb is valid for 2 consecutive cycles (STARVE_LIMIT=2).
   - A pipe issue with rd=4 sees issue_ready=0 until the skid drains; MD-source issues are not stalled.
4. Zero and error:
   - pipe_wb addr=0 -> grf_we stays 0.
   - pipe_wb addr=7 with busy[7]=0 -> write performed; wb_err=1 and held.
5. WAW:
   - Issue rd=10, src=1; a following issue with rd=10 gets issue_ready=0 until the MD write to 10 commits.
6. Reset mid-operation:
   - Assert reset with busy[12]=1 and the skid full.
   - Next cycle: grf_we=0, skid empty, wb_err=0, and an issue with rs=12 has issue_ready=1.

Source files
------------

// File: rtl/grf_wb_scheduler_pkg.sv
// Shared constants for the GRF writeback scheduler: register index width,
// the hardwired-zero register and the writer-source encoding.
package grf_wb_scheduler_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned REG_ZERO = 0;
  localparam logic        SRC_PIPE = 1'b0;
  localparam logic        SRC_MD   = 1'b1;

endpackage

// File: rtl/grf_wb_skid.sv
// One-entry holding buffer for an MD result that lost arbitration to the
// pipeline writeback, plus a saturating count of cycles it has waited.
module grf_wb_skid
  import grf_wb_scheduler_pkg::*;
#(
  parameter int unsigned AW           = REG_W,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic [AW-1:0]     in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_pc,
  output logic              valid,
  output logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] pc,
  output logic              starved
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] wait_q;

  // Capture on load, empty on drain, otherwise count waiting cycles (saturating).
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      addr   <= '0;
      data   <= '0;
      pc     <= '0;
      wait_q <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      addr   <= in_addr;
      data   <= in_data;
      pc     <= in_pc;
      wait_q <= '0;
    end else if (drain) begin
      valid  <= 1'b0;
      wait_q <= '0;
    end else if (valid && (wait_q < CW'(STARVE_LIMIT))) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  assign starved = valid && (wait_q >= CW'(STARVE_LIMIT));

endmodule

// File: rtl/grf_wb_scheduler.sv
// GRF write-port scheduler: busy-bit scoreboard gating issue on RAW/WAW
// hazards, and a pipe > skid > MD arbiter feeding the registered write port.
module grf_wb_scheduler
  import grf_wb_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NREG         = 32,
  parameter int unsigned STARVE_LIMIT = 2,
  localparam int unsigned AW          = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rs,
  input  logic [AW-1:0]     issue_rt,
  input  logic [AW-1:0]     issue_rd,
  input  logic              issue_src,
  output logic              issue_ready,
  input  logic              pipe_wb_valid,
  input  logic [AW-1:0]     pipe_wb_addr,
  input  logic [DATA_W-1:0] pipe_wb_data,
  input  logic [DATA_W-1:0] pipe_wb_pc,
  input  logic              md_wb_valid,
  output logic              md_wb_ready,
  input  logic [AW-1:0]     md_wb_addr,
  input  logic [DATA_W-1:0] md_wb_data,
  input  logic [DATA_W-1:0] md_wb_pc,
  output logic              grf_we,
  output logic [AW-1:0]     grf_a3,
  output logic [DATA_W-1:0] grf_wd,
  output logic [DATA_W-1:0] grf_pc,
  output logic              wb_err
);

  localparam logic [AW-1:0] Zero = AW'(REG_ZERO);

  logic [NREG-1:0]   busy_q, busy_d;
  logic              issue_acc, md_acc;
  logic              skid_valid, skid_starved, skid_load, skid_drain;
  logic [AW-1:0]     skid_addr;
  logic [DATA_W-1:0] skid_data, skid_pc;
  logic              win_valid, win_we;
  logic [AW-1:0]     win_addr;
  logic [DATA_W-1:0] win_data, win_pc;

  // Issue gate: RAW on either source, WAW on rd, and drain stall for pipe writers.
  always_comb begin
    issue_ready = 1'b1;
    if (busy_q[issue_rs] || busy_q[issue_rt]) issue_ready = 1'b0;
    if ((issue_rd != Zero) && busy_q[issue_rd]) issue_ready = 1'b0;
    if ((issue_src == SRC_PIPE) && (issue_rd != Zero) && skid_starved) issue_ready = 1'b0;
  end

  assign issue_acc = issue_valid && issue_ready;

  // Scoreboard update: commit clears first so a same-edge issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (grf_we) busy_d[grf_a3] = 1'b0;
    if (issue_acc && (issue_rd != Zero)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Arbitration: pipe cannot be stalled, so a colliding MD result parks in the skid.
  always_comb begin
    md_wb_ready = !skid_valid;
    md_acc      = md_wb_valid && !skid_valid;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    win_valid   = 1'b0;
    win_addr    = pipe_wb_addr;
    win_data    = pipe_wb_data;
    win_pc      = pipe_wb_pc;
    if (pipe_wb_valid) begin
      win_valid = 1'b1;
      skid_load = md_acc;
    end else if (skid_valid) begin
      win_valid  = 1'b1;
      skid_drain = 1'b1;
      win_addr   = skid_addr;
      win_data   = skid_data;
      win_pc     = skid_pc;
    end else if (md_acc) begin
      win_valid = 1'b1;
      win_addr  = md_wb_addr;
      win_data  = md_wb_data;
      win_pc    = md_wb_pc;
    end
    // Register 0 consumes the slot but never reaches the GRF.
    win_we = win_valid && (win_addr != Zero);
  end

  // Register the winner onto the GRF port; flag writes to registers with no outstanding writer.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      grf_we <= 1'b0;
      grf_a3 <= '0;
      grf_wd <= '0;
      grf_pc <= '0;
      wb_err <= 1'b0;
    end else begin
      busy_q <= busy_d;
      grf_we <= win_we;
      if (win_we) begin
        grf_a3 <= win_addr;
        grf_wd <= win_data;
        grf_pc <= win_pc;
        if (!busy_q[win_addr]) wb_err <= 1'b1;
      end
    end
  end

  grf_wb_skid #(
    .AW           (AW),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .drain   (skid_drain),
    .in_addr (md_wb_addr),
    .in_data (md_wb_data),
    .in_pc   (md_wb_pc),
    .valid   (skid_valid),
    .addr    (skid_addr),
    .data    (skid_data),
    .pc      (skid_pc),
    .starved (skid_starved)
  );

endmodule
